// File: rtl/dram_req_arbiter.sv
// Round-robin DRAM request arbiter with periodic refresh insertion in front of a controller FSM.
// Optional row-hit priority is enabled by defining DRAM_ARB_ROW_HIT_EN.
module dram_req_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int NUM_OF_BANKS     = 8,
    parameter int NUMBER_OF_ROWS   = 128,
    parameter int NUMBER_OF_COLS   = 8,
    parameter int REFRESH_INTERVAL = 64,
    localparam int BW = $clog2(NUM_OF_BANKS),
    localparam int RW = $clog2(NUMBER_OF_ROWS),
    localparam int CW = $clog2(NUMBER_OF_COLS),
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*BW-1:0] req_bank,
    input  logic [NUM_REQ*RW-1:0] req_row,
    input  logic [NUM_REQ*CW-1:0] req_col,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  ctrl_valid,
    output logic                  ctrl_we,
    output logic [BW-1:0]         ctrl_bank_id,
    output logic [RW-1:0]         ctrl_row_id,
    output logic [CW-1:0]         ctrl_col_id,
    input  logic                  ctrl_ready,
    input  logic                  ctrl_done,
    output logic                  refresh_flag,
    output logic [IW-1:0]         grant_id,
    output logic                  refresh_missed
);
    localparam int CNTW = $clog2(REFRESH_INTERVAL);

    // Handshake: a requester holds req_valid and its address until the one-cycle
    // req_ready pulse; the command is offered with ctrl_valid until ctrl_ready.
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, REFRESH} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [CNTW-1:0] ref_cnt;
    logic            refresh_pending;
    logic            ref_wrap, ref_clear;
    logic            any_valid, accept;
    logic            rr_found;
    logic [IW-1:0]   rr_win, rr_idx, win;

    assign any_valid = |req_valid;
    assign accept    = (state == IDLE) && !refresh_pending && any_valid && !rst;

    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        rr_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!rr_found && req_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx;
            end
        end
    end

`ifdef DRAM_ARB_ROW_HIT_EN
    logic          last_vld;
    logic [2:0]    hit_run;
    logic          hit_found, use_hit;
    logic [IW-1:0] hit_win;

    always_comb begin
        hit_found = 1'b0;
        hit_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hit_found && last_vld && req_valid[i] &&
                req_bank[i*BW +: BW] == ctrl_bank_id &&
                req_row[i*RW +: RW] == ctrl_row_id) begin
                hit_found = 1'b1;
                hit_win   = IW'(i);
            end
        end
    end

    // A run of four row-hit grants forces the next grant back to round-robin.
    assign use_hit = hit_found && (hit_run != 3'd4);
    assign win     = use_hit ? hit_win : rr_win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_vld <= 1'b0;
            hit_run  <= '0;
        end else if (accept) begin
            last_vld <= 1'b1;
            hit_run  <= use_hit ? hit_run + 3'd1 : 3'd0;
        end
    end
`else
    assign win = rr_win;
`endif

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (refresh_pending) state_nxt = REFRESH;
                else if (any_valid)  state_nxt = ISSUE;
            end
            ISSUE:     if (ctrl_ready) state_nxt = WAIT_DONE;
            WAIT_DONE: if (ctrl_done)  state_nxt = IDLE;
            REFRESH:   if (ctrl_done)  state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    assign ctrl_valid   = (state == ISSUE);
    assign refresh_flag = (state == REFRESH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            ctrl_we      <= 1'b0;
            ctrl_bank_id <= '0;
            ctrl_row_id  <= '0;
            ctrl_col_id  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                grant_id     <= win;
                rr_ptr       <= IW'((int'(win) + 1) % NUM_REQ);
                ctrl_we      <= req_we[win];
                ctrl_bank_id <= req_bank[int'(win)*BW +: BW];
                ctrl_row_id  <= req_row[int'(win)*RW +: RW];
                ctrl_col_id  <= req_col[int'(win)*CW +: CW];
            end
        end
    end

    // A wrap coinciding with the refresh completion re-arms pending rather than losing it.
    assign ref_wrap  = (ref_cnt == CNTW'(REFRESH_INTERVAL - 1));
    assign ref_clear = (state == REFRESH) && ctrl_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt         <= '0;
            refresh_pending <= 1'b0;
            refresh_missed  <= 1'b0;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + CNTW'(1);
            if (ref_wrap)       refresh_pending <= 1'b1;
            else if (ref_clear) refresh_pending <= 1'b0;
            if (ref_wrap && refresh_pending && !ref_clear) refresh_missed <= 1'b1;
        end
    end
endmodule
